archer_projectile_ctrl: RTL and testbench

Upstream control stage for archer_projectile_draw. It launches one arrow per mouse click when the archer class is active. Each frame it advances the arrow along a ballistic arc and retires it on a screen-edge exit, a hit, or the range limit. A cooldown then gates the next shot. Its registered outputs drive pos_x_proj, pos_y_proj, projectile_active, projectile_animated and flip_hor_archer of the draw stage directly.

---
 rtl/game_pkg.sv | 32 +++
 rtl/vga_pkg.sv | 11 +
 rtl/edge_detect.sv | 33 +++
 rtl/archer_projectile_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_archer_projectile_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Purpose : Types and tuning constants shared by the projectile controllers
//           (archer today, mage/warrior later).
// Ports   : none (package)
// ---------------------------------------------------------------------------
package game_pkg;

  // Common life cycle of a single projectile
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIGHT   = 2'd1,
    COOLDOWN = 2'd2
  } proj_state_t;

  localparam logic [1:0] ARCHER_CLASS = 2'd2;

  // Projectile tuning
  localparam int PROJ_SPEED           = 6;
  localparam int PROJ_VY_UP           = 8;
  localparam int PROJ_VY_MAX          = 8;
  localparam int PROJ_GRAV_DIV        = 4;
  localparam int PROJ_SPAWN_OFFSET    = 16;
  localparam int PROJ_RANGE_FRAMES    = 90;
  localparam int PROJ_COOLDOWN_FRAMES = 20;

  // Bits needed for a counter running 0 .. count-1 (never less than 1 bit)
  function automatic int cntWidth(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Purpose : Visible screen dimensions shared by every video-related block.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

endpackage

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Purpose : Registered rising-edge detector for a 1-bit level input
//           (mouse buttons and similar). o_rise is a one-cycle pulse that
//           appears the cycle after i_level goes from 0 to 1.
// Ports   : clk      - system clock
//           rst      - synchronous, active-high reset
//           i_level  - level input to watch
//           o_rise   - registered rising-edge pulse
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_level;
      r_rise <= i_level & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/archer_projectile_ctrl.sv
// ---------------------------------------------------------------------------
// archer_projectile_ctrl
// Purpose : Control stage feeding archer_projectile_draw. Launches one arrow
//           per click while the archer class is playing, moves it along a
//           ballistic arc once per frame, retires it on a screen-edge exit,
//           a hit, a class change or the range limit, then blocks new shots
//           for a cooldown period.
// Ports   : clk                    - system clock
//           rst                    - synchronous, active-high reset
//           i_frame_tick           - one-cycle pulse per frame
//           i_game_active[1:0]     - nonzero while gameplay runs
//           i_char_class[1:0]      - selected class (ARCHER_CLASS = archer)
//           i_mouse_clicked        - left mouse button level
//           i_mouse_x/i_mouse_y    - cursor position
//           i_player_x/i_player_y  - player centre
//           i_hit                  - arrow struck a target (level)
//           o_pos_x_proj/_y_proj   - arrow centre
//           o_projectile_active    - arrow in flight
//           o_projectile_animated  - arrow drawable (after first flight frame)
//           o_flip_hor_archer      - 1 = arrow flies left
// ---------------------------------------------------------------------------
module archer_projectile_ctrl
  import game_pkg::*;
  import vga_pkg::*;
#(
  parameter int SPEED           = PROJ_SPEED,
  parameter int VY_UP           = PROJ_VY_UP,
  parameter int VY_MAX          = PROJ_VY_MAX,
  parameter int GRAV_DIV        = PROJ_GRAV_DIV,
  parameter int SPAWN_OFFSET    = PROJ_SPAWN_OFFSET,
  parameter int RANGE_FRAMES    = PROJ_RANGE_FRAMES,
  parameter int COOLDOWN_FRAMES = PROJ_COOLDOWN_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_tick,
  input  logic [1:0]  i_game_active,
  input  logic [1:0]  i_char_class,
  input  logic        i_mouse_clicked,
  input  logic [11:0] i_mouse_x,
  input  logic [11:0] i_mouse_y,
  input  logic [11:0] i_player_x,
  input  logic [11:0] i_player_y,
  input  logic        i_hit,
  output logic [11:0] o_pos_x_proj,
  output logic [11:0] o_pos_y_proj,
  output logic        o_projectile_active,
  output logic        o_projectile_animated,
  output logic        o_flip_hor_archer
);

  localparam int FRAME_W = cntWidth(RANGE_FRAMES);
  localparam int COOL_W  = cntWidth(COOLDOWN_FRAMES);
  localparam int GRAV_W  = cntWidth(GRAV_DIV);

  localparam logic signed [12:0] STEP_RIGHT = 13'(SPEED);
  localparam logic signed [12:0] STEP_LEFT  = 13'(-SPEED);
  localparam logic signed [12:0] HOR_LIM    = 13'(HOR_PIXELS);
  localparam logic signed [12:0] VER_LIM    = 13'(VER_PIXELS);
  localparam logic signed [5:0]  VY_LAUNCH  = 6'(-VY_UP);
  localparam logic signed [5:0]  VY_LIMIT   = 6'(VY_MAX);
  localparam logic [11:0]        SPAWN_DX   = 12'(SPAWN_OFFSET);

  localparam logic [FRAME_W-1:0] RANGE_LAST = FRAME_W'(RANGE_FRAMES - 1);
  localparam logic [COOL_W-1:0]  COOL_LAST  = COOL_W'(COOLDOWN_FRAMES - 1);
  localparam logic [GRAV_W-1:0]  GRAV_LAST  = GRAV_W'(GRAV_DIV - 1);

  // Current state and registered outputs
  proj_state_t         r_state;
  logic [11:0]         r_posX;
  logic [11:0]         r_posY;
  logic signed [5:0]   r_vy;
  logic [FRAME_W-1:0]  r_frameCnt;
  logic [GRAV_W-1:0]   r_gravCnt;
  logic [COOL_W-1:0]   r_coolCnt;
  logic                r_flip;
  logic                r_active;
  logic                r_animated;

  // Next-state values
  proj_state_t         w_stateNext;
  logic [11:0]         w_posXNext;
  logic [11:0]         w_posYNext;
  logic signed [5:0]   w_vyNext;
  logic [FRAME_W-1:0]  w_frameCntNext;
  logic [GRAV_W-1:0]   w_gravCntNext;
  logic [COOL_W-1:0]   w_coolCntNext;
  logic                w_flipNext;
  logic                w_activeNext;
  logic                w_animatedNext;

  // Candidate move, one bit wider than the screen so a step past 0 shows up
  // as a negative value instead of wrapping to a large coordinate
  logic                w_clickRise;
  logic signed [12:0]  w_nx;
  logic signed [12:0]  w_ny;
  logic                w_offScreen;
  logic                w_rangeDone;
  logic                w_classLost;
  logic signed [5:0]   w_vyFall;

  edge_detect u_clickEdge (
    .clk     (clk),
    .rst     (rst),
    .i_level (i_mouse_clicked),
    .o_rise  (w_clickRise)
  );

  assign w_nx = $signed({1'b0, r_posX}) + (r_flip ? STEP_LEFT : STEP_RIGHT);
  assign w_ny = $signed({1'b0, r_posY}) + $signed({{7{r_vy[5]}}, r_vy});

  assign w_offScreen = (w_nx < 13'sd0) || (w_nx >= HOR_LIM) ||
                       (w_ny < 13'sd0) || (w_ny >= VER_LIM);
  assign w_rangeDone = (r_frameCnt == RANGE_LAST);
  assign w_classLost = (i_char_class != ARCHER_CLASS);

  // Gravity only ever pulls downward and stops at the terminal speed
  assign w_vyFall = (r_vy >= VY_LIMIT) ? VY_LIMIT : r_vy + 6'sd1;

  // Next-state logic. Leaving gameplay overrides everything; within FLIGHT
  // a hit or class change retires the arrow before any frame movement.
  always_comb begin
    w_stateNext    = r_state;
    w_posXNext     = r_posX;
    w_posYNext     = r_posY;
    w_vyNext       = r_vy;
    w_frameCntNext = r_frameCnt;
    w_gravCntNext  = r_gravCnt;
    w_coolCntNext  = r_coolCnt;
    w_flipNext     = r_flip;
    w_activeNext   = r_active;
    w_animatedNext = r_animated;

    if (i_game_active == 2'd0) begin
      w_stateNext    = IDLE;
      w_posXNext     = '0;
      w_posYNext     = '0;
      w_vyNext       = '0;
      w_frameCntNext = '0;
      w_gravCntNext  = '0;
      w_coolCntNext  = '0;
      w_flipNext     = 1'b0;
      w_activeNext   = 1'b0;
      w_animatedNext = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_clickRise && !w_classLost) begin
            w_stateNext    = FLIGHT;
            w_flipNext     = (i_mouse_x < i_player_x);
            w_posXNext     = (i_mouse_x < i_player_x) ? i_player_x - SPAWN_DX
                                                      : i_player_x + SPAWN_DX;
            w_posYNext     = i_player_y;
            w_vyNext       = (i_mouse_y < i_player_y) ? VY_LAUNCH : 6'sd0;
            w_frameCntNext = '0;
            w_gravCntNext  = '0;
            w_activeNext   = 1'b1;
            w_animatedNext = 1'b0;
          end
        end

        FLIGHT: begin
          if (i_hit || w_classLost ||
              (i_frame_tick && (w_offScreen || w_rangeDone))) begin
            w_stateNext    = COOLDOWN;
            w_coolCntNext  = '0;
            w_activeNext   = 1'b0;
            w_animatedNext = 1'b0;
          end else if (i_frame_tick) begin
            w_posXNext     = w_nx[11:0];
            w_posYNext     = w_ny[11:0];
            w_animatedNext = 1'b1;
            w_frameCntNext = r_frameCnt + 1'b1;
            if (r_gravCnt == GRAV_LAST) begin
              w_gravCntNext = '0;
              w_vyNext      = w_vyFall;
            end else begin
              w_gravCntNext = r_gravCnt + 1'b1;
            end
          end
        end

        COOLDOWN: begin
          if (i_frame_tick) begin
            if (r_coolCnt == COOL_LAST) begin
              w_stateNext   = IDLE;
              w_coolCntNext = '0;
            end else begin
              w_coolCntNext = r_coolCnt + 1'b1;
            end
          end
        end

        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_posX     <= '0;
      r_posY     <= '0;
      r_vy       <= '0;
      r_frameCnt <= '0;
      r_gravCnt  <= '0;
      r_coolCnt  <= '0;
      r_flip     <= 1'b0;
      r_active   <= 1'b0;
      r_animated <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_posX     <= w_posXNext;
      r_posY     <= w_posYNext;
      r_vy       <= w_vyNext;
      r_frameCnt <= w_frameCntNext;
      r_gravCnt  <= w_gravCntNext;
      r_coolCnt  <= w_coolCntNext;
      r_flip     <= w_flipNext;
      r_active   <= w_activeNext;
      r_animated <= w_animatedNext;
    end
  end

  assign o_pos_x_proj          = r_posX;
  assign o_pos_y_proj          = r_posY;
  assign o_projectile_active   = r_active;
  assign o_projectile_animated = r_animated;
  assign o_flip_hor_archer     = r_flip;

endmodule

// File: tb/tb_archer_projectile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_archer_projectile_ctrl
// Purpose : Self-checking bench for archer_projectile_ctrl. A behavioural
//           model tracks the arrow in plain integers and is compared with
//           the DUT on every cycle; directed scenarios add literal checks.
// Ports   : none (top-level bench)
// ---------------------------------------------------------------------------
module tb_archer_projectile_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frameTick;
  logic [1:0]  gameActive;
  logic [1:0]  charClass;
  logic        mouseClicked;
  logic [11:0] mouseX;
  logic [11:0] mouseY;
  logic [11:0] playerX;
  logic [11:0] playerY;
  logic        hit;
  logic [11:0] posX;
  logic [11:0] posY;
  logic        projActive;
  logic        projAnimated;
  logic        flipHor;

  int compared   = 0;
  int mismatched = 0;
  bit compareEnable = 1'b0;

  // Model of the arrow: mode 0 = waiting, 1 = flying, 2 = cooling down
  int mMode;
  int mPosX;
  int mPosY;
  int mVy;
  int mFlights;
  int mCoolTicks;
  bit mFlip;
  bit mActive;
  bit mAnimated;
  bit mPrevClick;
  bit mEdge;

  always #5 clk = ~clk;

  archer_projectile_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_frame_tick          (frameTick),
    .i_game_active         (gameActive),
    .i_char_class          (charClass),
    .i_mouse_clicked       (mouseClicked),
    .i_mouse_x             (mouseX),
    .i_mouse_y             (mouseY),
    .i_player_x            (playerX),
    .i_player_y            (playerY),
    .i_hit                 (hit),
    .o_pos_x_proj          (posX),
    .o_pos_y_proj          (posY),
    .o_projectile_active   (projActive),
    .o_projectile_animated (projAnimated),
    .o_flip_hor_archer     (flipHor)
  );

  // Single comparison: counts it and reports a failure line when it differs
  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Hand-computed expectation for all five outputs
  task automatic checkState(input string tag, input int ex, input int ey,
                            input int act, input int anim, input int flip);
    checkOutput({tag, " pos_x"}, int'(posX), ex);
    checkOutput({tag, " pos_y"}, int'(posY), ey);
    checkOutput({tag, " active"}, int'(projActive), act);
    checkOutput({tag, " animated"}, int'(projAnimated), anim);
    checkOutput({tag, " flip"}, int'(flipHor), flip);
  endtask

  task automatic modelClear();
    mMode      = 0;
    mPosX      = 0;
    mPosY      = 0;
    mVy        = 0;
    mFlights   = 0;
    mCoolTicks = 0;
    mFlip      = 1'b0;
    mActive    = 1'b0;
    mAnimated  = 1'b0;
  endtask

  task automatic modelRetire();
    mMode      = 2;
    mActive    = 1'b0;
    mAnimated  = 1'b0;
    mCoolTicks = 0;
  endtask

  // One clock of the arrow's rules, using the inputs seen at this edge
  task automatic modelStep();
    bit launchEdge;
    int nx;
    int ny;
    launchEdge = mEdge;
    if (rst) begin
      modelClear();
      mPrevClick = 1'b0;
      mEdge      = 1'b0;
      return;
    end
    mEdge      = mouseClicked && !mPrevClick;
    mPrevClick = mouseClicked;
    if (gameActive == 2'd0) begin
      modelClear();
      return;
    end
    if (mMode == 0) begin
      if (launchEdge && charClass == 2'd2) begin
        mFlip     = (mouseX < playerX);
        mPosX     = mFlip ? (int'(playerX) - 16 + 4096) % 4096 : (int'(playerX) + 16) % 4096;
        mPosY     = int'(playerY);
        mVy       = (mouseY < playerY) ? -8 : 0;
        mFlights  = 0;
        mActive   = 1'b1;
        mAnimated = 1'b0;
        mMode     = 1;
      end
    end else if (mMode == 1) begin
      if (hit || charClass != 2'd2) begin
        modelRetire();
      end else if (frameTick) begin
        nx = mPosX + (mFlip ? -6 : 6);
        ny = mPosY + mVy;
        if (nx < 0 || nx >= 1024 || ny < 0 || ny >= 768 || mFlights == 89) begin
          modelRetire();
        end else begin
          mPosX     = nx;
          mPosY     = ny;
          mAnimated = 1'b1;
          mFlights++;
          if (mFlights % 4 == 0 && mVy < 8) mVy++;
        end
      end
    end else begin
      if (frameTick) begin
        mCoolTicks++;
        if (mCoolTicks == 20) mMode = 0;
      end
    end
  endtask

  always @(posedge clk) modelStep();

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (compareEnable) begin
      checkOutput("model pos_x", int'(posX), mPosX);
      checkOutput("model pos_y", int'(posY), mPosY);
      checkOutput("model active", int'(projActive), int'(mActive));
      checkOutput("model animated", int'(projAnimated), int'(mAnimated));
      checkOutput("model flip", int'(flipHor), int'(mFlip));
    end
  end

  task automatic applyStimulus(input int px, input int py, input int mx, input int my);
    @(negedge clk);
    playerX = 12'(px);
    playerY = 12'(py);
    mouseX  = 12'(mx);
    mouseY  = 12'(my);
  endtask

  // Returns on the first negedge at which the launch is visible
  task automatic clickMouse();
    @(negedge clk);
    mouseClicked = 1'b1;
    @(negedge clk);
    mouseClicked = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseTick(input bit withHit);
    @(negedge clk);
    frameTick = 1'b1;
    hit       = withHit;
    @(negedge clk);
    frameTick = 1'b0;
    hit       = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulseTick(1'b0);
  endtask

  task automatic pulseHit();
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    frameTick    = 1'b0;
    gameActive   = 2'd1;
    charClass    = 2'd2;
    mouseClicked = 1'b0;
    mouseX       = '0;
    mouseY       = '0;
    playerX      = '0;
    playerY      = '0;
    hit          = 1'b0;
    modelClear();
    mPrevClick = 1'b0;
    mEdge      = 1'b0;

    repeat (3) @(negedge clk);
    compareEnable = 1'b1;
    checkState("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    $display("[TB] launch right");
    applyStimulus(400, 300, 600, 300);
    clickMouse();
    checkState("right launch", 416, 300, 1, 0, 0);
    pulseTick(1'b0);
    checkState("right tick1", 422, 300, 1, 1, 0);
    pulseHit();
    checkState("right hit", 422, 300, 0, 0, 0);
    ticks(20);

    $display("[TB] launch left and up");
    applyStimulus(400, 300, 100, 200);
    clickMouse();
    checkState("left launch", 384, 300, 1, 0, 1);
    pulseTick(1'b0);
    checkState("left tick1", 378, 292, 1, 1, 1);
    ticks(3);
    checkState("left tick4", 360, 268, 1, 1, 1);
    pulseTick(1'b0);
    checkState("left tick5", 354, 261, 1, 1, 1);
    pulseHit();
    checkState("left retired flip held", 354, 261, 0, 0, 1);
    ticks(20);

    $display("[TB] right edge exit");
    applyStimulus(1000, 300, 1100, 300);
    clickMouse();
    checkState("edge launch", 1016, 300, 1, 0, 0);
    pulseTick(1'b0);
    checkState("edge tick1", 1022, 300, 1, 1, 0);
    pulseTick(1'b0);
    checkState("edge exit", 1022, 300, 0, 0, 0);
    ticks(20);

    $display("[TB] top edge exit");
    applyStimulus(500, 10, 600, 0);
    clickMouse();
    checkState("top launch", 516, 10, 1, 0, 0);
    pulseTick(1'b0);
    checkState("top tick1", 522, 2, 1, 1, 0);
    pulseTick(1'b0);
    checkState("top exit", 522, 2, 0, 0, 0);
    ticks(20);

    $display("[TB] hit with frame tick");
    applyStimulus(400, 300, 600, 300);
    clickMouse();
    ticks(5);
    checkState("hit tick5", 446, 301, 1, 1, 0);
    pulseTick(1'b1);
    checkState("hit priority", 446, 301, 0, 0, 0);

    $display("[TB] cooldown gating");
    ticks(10);
    clickMouse();
    checkState("cooldown click ignored", 446, 301, 0, 0, 0);
    ticks(10);
    clickMouse();
    checkState("after cooldown launch", 416, 300, 1, 0, 0);
    @(negedge clk);
    charClass = 2'd1;
    @(negedge clk);
    checkState("class change retires", 416, 300, 0, 0, 0);
    ticks(20);
    clickMouse();
    checkState("non-archer click 1", 416, 300, 0, 0, 0);
    clickMouse();
    checkState("non-archer click 2", 416, 300, 0, 0, 0);
    charClass = 2'd2;

    $display("[TB] reset and abort mid-flight");
    clickMouse();
    checkState("pre-reset launch", 416, 300, 1, 0, 0);
    ticks(2);
    checkState("pre-reset tick2", 428, 300, 1, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkState("mid-flight reset", 0, 0, 0, 0, 0);
    clickMouse();
    checkState("post-reset launch", 416, 300, 1, 0, 0);
    ticks(1);
    @(negedge clk);
    gameActive = 2'd0;
    @(negedge clk);
    gameActive = 2'd3;
    checkState("game abort", 0, 0, 0, 0, 0);
    clickMouse();
    checkState("post-abort launch", 416, 300, 1, 0, 0);
    @(negedge clk);
    gameActive = 2'd0;
    @(negedge clk);
    gameActive = 2'd1;

    $display("[TB] range limit");
    applyStimulus(100, 300, 600, 200);
    clickMouse();
    checkState("range launch", 116, 300, 1, 0, 0);
    ticks(89);
    checkState("range tick89", 650, 468, 1, 1, 0);
    pulseTick(1'b0);
    checkState("range expired", 650, 468, 0, 0, 0);
    ticks(2);

    @(negedge clk);
    compareEnable = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
